rc5_decipher_sched: RTL

//  Block-level sequencer for the RC5 decipher core. Accepts one ciphertext block (A,B) per

---
 rtl/rc5_pkg.sv | 8 +
 rtl/rc5_wdog.sv | 28 ++
 rtl/rc5_decipher_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// Shared state encoding and default sizing for the RC5 decipher block sequencer.
package rc5_pkg;
  typedef enum logic [1:0] {SCH_IDLE, SCH_RUN, SCH_DRAIN, SCH_OUT} sch_state_t;

  localparam int RC5_W         = 32;
  localparam int RC5_R         = 12;
  localparam int RC5_FINAL_LAT = 3;
endpackage

// File: rtl/rc5_wdog.sv
// Loadable up-counter; tc is high while the count equals TC.
// Used both as the RUN watchdog and as the DRAIN delay counter.
module rc5_wdog #(
  parameter int unsigned    CW = 8,
  parameter logic [CW-1:0]  TC = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic          tc
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)      cnt_d = ld_val;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC);
endmodule

// File: rtl/rc5_decipher_sched.sv
// Block sequencer around the RC5 decipher core: one ciphertext block in, one plaintext out,
// with a RUN watchdog, abort on key invalidation and a delivered-block counter.
module rc5_decipher_sched
  import rc5_pkg::*;
#(
  parameter int W         = RC5_W,
  parameter int R         = RC5_R,
  parameter int FINAL_LAT = RC5_FINAL_LAT,
  parameter int TIMEOUT   = (9*R + 4 < 256) ? 256 : 2*(9*R + 4),
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iKeyReady,
  input  logic             iValid,
  output logic             oReady,
  input  logic [W-1:0]     iA,
  input  logic [W-1:0]     iB,
  output logic             oValid,
  input  logic             iReady,
  output logic [W-1:0]     oA,
  output logic [W-1:0]     oB,
  output logic             oCoreStart,
  output logic [W-1:0]     oCoreA,
  output logic [W-1:0]     oCoreB,
  input  logic             iCoreDone,
  input  logic [W-1:0]     iCoreA,
  input  logic [W-1:0]     iCoreB,
  output logic             oAbort,
  output logic             oError,
  output logic [CNT_W-1:0] oBlkCount
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int DL_W = (FINAL_LAT > 1) ? $clog2(FINAL_LAT) : 1;

  sch_state_t       state_q, state_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     core_a_q, core_a_d, core_b_q, core_b_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             wd_tc, dl_tc;

  // Both counters sit at zero outside their own state, so each starts fresh on entry.
  rc5_wdog #(.CW(WD_W), .TC(WD_W'(TIMEOUT - 1))) u_wdog (
    .clk(clk), .rst(rst), .ld(state_q != SCH_RUN), .ld_val('0),
    .en(state_q == SCH_RUN), .tc(wd_tc)
  );

  rc5_wdog #(.CW(DL_W), .TC(DL_W'(FINAL_LAT - 1))) u_dcnt (
    .clk(clk), .rst(rst), .ld(state_q != SCH_DRAIN), .ld_val('0),
    .en(state_q == SCH_DRAIN), .tc(dl_tc)
  );

  assign oReady = (state_q == SCH_IDLE) && iKeyReady && !rst;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    abort_d   = 1'b0;
    err_d     = err_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    core_a_d  = core_a_q;
    core_b_d  = core_b_q;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      SCH_IDLE: if (iValid && oReady) begin
        core_a_d = iA;
        core_b_d = iB;
        start_d  = 1'b1;
        state_d  = SCH_RUN;
      end
      SCH_RUN: begin
        // Key loss beats a same-cycle done: the S-table under the core is no longer trusted.
        if (!iKeyReady) begin
          abort_d = 1'b1;
          start_d = 1'b0;
          state_d = SCH_IDLE;
        end else if (iCoreDone) begin
          state_d = SCH_DRAIN;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = SCH_IDLE;
        end
      end
      SCH_DRAIN: begin
        if (!iKeyReady) begin
          abort_d = 1'b1;
          start_d = 1'b0;
          state_d = SCH_IDLE;
        end else if (dl_tc) begin
          a_d     = iCoreA;
          b_d     = iCoreB;
          valid_d = 1'b1;
          start_d = 1'b0;
          state_d = SCH_OUT;
        end
      end
      SCH_OUT: if (iReady) begin
        valid_d   = 1'b0;
        blk_cnt_d = blk_cnt_q + 1'b1;
        state_d   = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCH_IDLE;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      core_a_q  <= '0;
      core_b_q  <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      core_a_q  <= core_a_d;
      core_b_q  <= core_b_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign oCoreStart = start_q;
  assign oAbort     = abort_q;
  assign oError     = err_q;
  assign oValid     = valid_q;
  assign oA         = a_q;
  assign oB         = b_q;
  assign oCoreA     = core_a_q;
  assign oCoreB     = core_b_q;
  assign oBlkCount  = blk_cnt_q;
endmodule
